// File: rtl/bin_pkg.sv
// Shared types, reset defaults and sizing helpers for the adaptive binarizer.
package bin_pkg;

    typedef enum logic {
        BIN_LOCAL  = 1'b0,
        BIN_GLOBAL = 1'b1
    } bin_mode_e;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } bin_state_e;

    localparam bin_mode_e CFG_MODE_RST   = BIN_LOCAL;
    localparam int        CFG_OFFSET_RST = 0;
    localparam int        CFG_THRESH_RST = 128;
    localparam logic      CFG_INVERT_RST = 1'b0;

    function automatic int win_n(input int win);
        return win * win;
    endfunction

    function automatic int sum_w(input int dw, input int win);
        return dw + $clog2(win * win);
    endfunction

endpackage

// File: rtl/bin_line_buf.sv
// WIN-1 cascaded line RAMs: each write shifts the column one line deeper,
// and the pre-write contents of every line are presented on registered outputs.
module bin_line_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int LINES      = 2,
    parameter int DEPTH      = 800,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             we,
    input  logic [AW-1:0]                    addr,
    input  logic [DATA_WIDTH-1:0]            din,
    output logic [LINES-1:0][DATA_WIDTH-1:0] rd
);

    logic [DATA_WIDTH-1:0] mem_r [LINES][DEPTH];

    // Cascade write: newest pixel into line 0, older lines move down one slot
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[0][addr] <= din;
            for (int k = 1; k < LINES; k++) begin
                mem_r[k][addr] <= mem_r[k-1][addr];
            end
        end
    end

    // Registered read of the old column contents (read-before-write)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd <= '0;
        end else if (we) begin
            for (int k = 0; k < LINES; k++) begin
                rd[k] <= mem_r[k][addr];
            end
        end
    end

endmodule

// File: rtl/adaptive_bin.sv
// Local-adaptive / global-threshold binarizer with a fixed 4-clock pipeline.
// Output pixel (r,c) carries the decision for source pixel (r-R, c-R).
module adaptive_bin
    import bin_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WIN        = 3,
    parameter int H_DISP     = 800,
    parameter int V_DISP     = 600
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pre_img_vsync,
    input  logic                  pre_img_hsync,
    input  logic                  pre_img_valid,
    input  logic [DATA_WIDTH-1:0] pre_img_data,
    input  logic                  cfg_mode,
    input  logic [DATA_WIDTH:0]   cfg_offset,
    input  logic [DATA_WIDTH-1:0] cfg_thresh,
    input  logic                  cfg_invert,
    output logic                  post_img_vsync,
    output logic                  post_img_hsync,
    output logic                  post_img_valid,
    output logic [DATA_WIDTH-1:0] post_img_data
);

    localparam int R     = WIN / 2;
    localparam int N     = win_n(WIN);
    localparam int SUM_W = sum_w(DATA_WIDTH, WIN);
    localparam int COL_W = DATA_WIDTH + $clog2(WIN);
    localparam int CMP_W = SUM_W + 2;
    localparam int CW    = $clog2(H_DISP + 1);
    localparam int RW    = $clog2(V_DISP + 1);
    localparam int AW    = $clog2(H_DISP);
    localparam logic signed [CMP_W-1:0] N_CMP = CMP_W'(N);

    logic                  vs_d_r, va_d_r;
    logic                  vs_rise_s, va_fall_s;
    bin_state_e            state_r, state_nx_s;
    logic                  run_s;
    logic [CW-1:0]         col_r, cur_col_s;
    logic [RW-1:0]         row_r, cur_row_s;
    logic                  in_range_s, we_s, interior_s;

    bin_mode_e             cfg_mode_r;
    logic [DATA_WIDTH:0]   cfg_offset_r;
    logic [DATA_WIDTH-1:0] cfg_thresh_r;
    logic                  cfg_invert_r;

    logic [2:0]            vs_pipe_r, hs_pipe_r, va_pipe_r, int_pipe_r;

    logic [DATA_WIDTH-1:0]            pix_r;
    logic [WIN-2:0][DATA_WIDTH-1:0]   rd_s;
    logic [DATA_WIDTH-1:0]            col_s1_s [WIN];
    logic [COL_W-1:0]                 colsum_s;
    logic [COL_W-1:0]                 cs_r [WIN];
    logic [DATA_WIDTH-1:0]            ctr_r [R+1];
    logic [SUM_W-1:0]                 winsum_s, sum_r;
    logic [DATA_WIDTH-1:0]            center_r;

    logic signed [CMP_W-1:0]          lhs_s, off_ext_s, rhs_s;
    logic                             fg_local_s, fg_global_s, fg_s;

    assign vs_rise_s  = pre_img_vsync & ~vs_d_r;
    assign va_fall_s  = va_d_r & ~pre_img_valid;
    // A coincident vsync rise places the pixel at (0,0)
    assign cur_col_s  = vs_rise_s ? '0 : col_r;
    assign cur_row_s  = vs_rise_s ? '0 : row_r;
    assign in_range_s = (cur_col_s < CW'(H_DISP));
    assign we_s       = pre_img_valid & in_range_s;
    assign interior_s = in_range_s && (cur_col_s >= CW'(2 * R)) && (cur_row_s >= RW'(2 * R));

    // Sync edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d_r <= 1'b0;
            va_d_r <= 1'b0;
        end else begin
            vs_d_r <= pre_img_vsync;
            va_d_r <= pre_img_valid;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= WAIT_FRAME;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            WAIT_FRAME: begin
                if (vs_rise_s) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = WAIT_FRAME;
                end
            end
            RUN:     state_nx_s = RUN;
            default: state_nx_s = WAIT_FRAME;
        endcase
    end

    // FSM output: a frame is processed from its own vsync rise onwards
    always_comb begin
        run_s = 1'b0;
        case (state_r)
            WAIT_FRAME: run_s = vs_rise_s;
            RUN:        run_s = 1'b1;
            default:    run_s = 1'b0;
        endcase
    end

    // Column and row counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= '0;
            row_r <= '0;
        end else if (vs_rise_s) begin
            col_r <= pre_img_valid ? CW'(1) : CW'(0);
            row_r <= '0;
        end else if (va_fall_s) begin
            col_r <= '0;
            if (row_r != RW'(V_DISP)) begin
                row_r <= row_r + RW'(1);
            end
        end else if (pre_img_valid && (col_r != CW'(H_DISP))) begin
            col_r <= col_r + CW'(1);
        end
    end

    // Frame-stable configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mode_r   <= CFG_MODE_RST;
            cfg_offset_r <= (DATA_WIDTH + 1)'(CFG_OFFSET_RST);
            cfg_thresh_r <= DATA_WIDTH'(CFG_THRESH_RST);
            cfg_invert_r <= CFG_INVERT_RST;
        end else if (vs_rise_s) begin
            cfg_mode_r   <= bin_mode_e'(cfg_mode);
            cfg_offset_r <= cfg_offset;
            cfg_thresh_r <= cfg_thresh;
            cfg_invert_r <= cfg_invert;
        end
    end

    bin_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINES      (WIN - 1),
        .DEPTH      (H_DISP),
        .AW         (AW)
    ) u_line_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we_s),
        .addr (AW'(cur_col_s)),
        .din  (pre_img_data),
        .rd   (rd_s)
    );

    // Stage 1: current pixel alongside the line-buffer outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_r <= '0;
        end else begin
            pix_r <= pre_img_data;
        end
    end

    // Column vector (index k = source row r-k) and its sum
    always_comb begin
        col_s1_s[0] = pix_r;
        for (int k = 0; k < WIN - 1; k++) begin
            col_s1_s[k+1] = rd_s[k];
        end
        colsum_s = '0;
        for (int k = 0; k < WIN; k++) begin
            colsum_s = colsum_s + COL_W'(col_s1_s[k]);
        end
    end

    // Stage 2: horizontal shift of column sums and of the centre row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN; i++) cs_r[i] <= '0;
            for (int i = 0; i <= R; i++)  ctr_r[i] <= '0;
        end else begin
            cs_r[0]  <= colsum_s;
            ctr_r[0] <= col_s1_s[R];
            for (int i = 1; i < WIN; i++) cs_r[i] <= cs_r[i-1];
            for (int i = 1; i <= R; i++)  ctr_r[i] <= ctr_r[i-1];
        end
    end

    // Window sum over the WIN most recent column sums
    always_comb begin
        winsum_s = '0;
        for (int i = 0; i < WIN; i++) begin
            winsum_s = winsum_s + SUM_W'(cs_r[i]);
        end
    end

    // Stage 3: window sum and delayed centre
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r    <= '0;
            center_r <= '0;
        end else begin
            sum_r    <= winsum_s;
            center_r <= ctr_r[R];
        end
    end

    // Division-free decision: centre*N against S + offset*N, signed
    always_comb begin
        lhs_s       = $signed({{(CMP_W - DATA_WIDTH){1'b0}}, center_r}) * N_CMP;
        off_ext_s   = $signed({{(CMP_W - DATA_WIDTH - 1){cfg_offset_r[DATA_WIDTH]}}, cfg_offset_r});
        rhs_s       = $signed({2'b00, sum_r}) + (off_ext_s * N_CMP);
        fg_local_s  = (lhs_s > rhs_s);
        fg_global_s = (center_r > cfg_thresh_r);
        if (cfg_mode_r == BIN_GLOBAL) begin
            fg_s = fg_global_s;
        end else begin
            fg_s = fg_local_s;
        end
    end

    // Sync/valid/border pipeline and stage-4 output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_pipe_r      <= '0;
            hs_pipe_r      <= '0;
            va_pipe_r      <= '0;
            int_pipe_r     <= '0;
            post_img_vsync <= 1'b0;
            post_img_hsync <= 1'b0;
            post_img_valid <= 1'b0;
            post_img_data  <= '0;
        end else begin
            vs_pipe_r      <= {vs_pipe_r[1:0], pre_img_vsync};
            hs_pipe_r      <= {hs_pipe_r[1:0], pre_img_hsync};
            va_pipe_r      <= {va_pipe_r[1:0], pre_img_valid & run_s};
            int_pipe_r     <= {int_pipe_r[1:0], interior_s};
            post_img_vsync <= vs_pipe_r[2];
            post_img_hsync <= hs_pipe_r[2];
            post_img_valid <= va_pipe_r[2];
            post_img_data  <= (va_pipe_r[2] && int_pipe_r[2] && (fg_s ^ cfg_invert_r))
                              ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_adaptive_bin.sv
// Scoreboard bench for adaptive_bin: frame table plus invert-toggle and mid-frame reset sequences.
module tb_adaptive_bin;

    localparam int WIN  = 3;
    localparam int R    = WIN / 2;
    localparam int MAXR = 320;
    localparam int MAXC = 144;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pre_img_vsync, pre_img_hsync, pre_img_valid;
    logic [7:0] pre_img_data;
    logic       cfg_mode;
    logic [8:0] cfg_offset;
    logic [7:0] cfg_thresh;
    logic       cfg_invert;
    logic       post_img_vsync, post_img_hsync, post_img_valid;
    logic [7:0] post_img_data;

    adaptive_bin #(
        .DATA_WIDTH(8),
        .WIN       (WIN),
        .H_DISP    (800),
        .V_DISP    (600)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pre_img_vsync (pre_img_vsync),
        .pre_img_hsync (pre_img_hsync),
        .pre_img_valid (pre_img_valid),
        .pre_img_data  (pre_img_data),
        .cfg_mode      (cfg_mode),
        .cfg_offset    (cfg_offset),
        .cfg_thresh    (cfg_thresh),
        .cfg_invert    (cfg_invert),
        .post_img_vsync(post_img_vsync),
        .post_img_hsync(post_img_hsync),
        .post_img_valid(post_img_valid),
        .post_img_data (post_img_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] bits;
        int          r;
        int          c;
        bit          pix;
    } exp_t;

    typedef struct {
        int         pat;
        int         w;
        int         h;
        int         mode;
        int         off;
        int         thr;
        int         inv;
        int         pr;
        int         pc;
        logic [7:0] pv;
    } vec_t;

    exp_t       q[$];
    vec_t       vecs[11];
    logic [7:0] img [MAXR][MAXC];
    int         checks = 0;
    int         errors = 0;
    int         pr_r, pr_c;
    logic [7:0] pr_v;
    bit         pr_hit;
    logic       run_m, vsp_m;
    int         mode_m, off_m, thr_m, inv_m;

    function automatic logic [7:0] model_pix(input int r, input int c);
        int s, ctr;
        bit fg;
        if (r < 2 * R || c < 2 * R) return 8'h00;
        s = 0;
        for (int dr = 0; dr < WIN; dr++)
            for (int dc = 0; dc < WIN; dc++)
                s += int'(img[r-dr][c-dc]);
        ctr = int'(img[r-R][c-R]);
        if (mode_m != 0) fg = (ctr > thr_m);
        else             fg = (ctr * WIN * WIN > s + off_m * WIN * WIN);
        return (fg != (inv_m != 0)) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] pattern(input int pat, input int r, input int c);
        case (pat)
            0:       return 8'd100;
            1:       return (r == 10 && c == 10) ? 8'd200 : 8'd50;
            2:       return 8'(c);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic tick(input logic vs, input logic hs, input logic va,
                        input logic [7:0] d, input int r, input int c);
        exp_t e, got;
        logic rise, ve;
        logic [7:0] de;
        pre_img_vsync = vs;
        pre_img_hsync = hs;
        pre_img_valid = va;
        pre_img_data  = d;
        if (!rst_n) begin
            e.bits = '0; e.r = -1; e.c = -1; e.pix = 1'b0;
            run_m = 1'b0; vsp_m = 1'b0;
        end else begin
            rise  = vs & ~vsp_m;
            vsp_m = vs;
            if (rise) begin
                mode_m = int'(cfg_mode);
                off_m  = int'($signed(cfg_offset));
                thr_m  = int'(cfg_thresh);
                inv_m  = int'(cfg_invert);
                run_m  = 1'b1;
            end
            ve = va & run_m;
            de = ve ? model_pix(r, c) : 8'h00;
            e.bits = {vs, hs, ve, de}; e.r = r; e.c = c; e.pix = ve;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 4) begin
            got = q.pop_front();
            checks++;
            if ({post_img_vsync, post_img_hsync, post_img_valid, post_img_data} !== got.bits) begin
                errors++;
                $display("FAIL stream r=%0d c=%0d got vs/hs/va/data=%h required %h", got.r, got.c,
                         {post_img_vsync, post_img_hsync, post_img_valid, post_img_data}, got.bits);
            end
            if (got.pix && got.r == pr_r && got.c == pr_c) begin
                pr_hit = 1'b1;
                checks++;
                if (post_img_data !== pr_v) begin
                    errors++;
                    $display("FAIL probe (%0d,%0d) got %h required %h", pr_r, pr_c, post_img_data, pr_v);
                end
            end
        end
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({post_img_vsync, post_img_hsync, post_img_valid, post_img_data} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset got %h required 000",
                     {post_img_vsync, post_img_hsync, post_img_valid, post_img_data});
        end
        foreach (q[i]) begin
            q[i].bits = '0;
            q[i].pix  = 1'b0;
        end
        run_m = 1'b0;
        vsp_m = 1'b0;
    endtask

    task automatic run_frame(input int pat, input int w, input int h, input int mode,
                             input int off, input int thr, input int inv,
                             input int chg_row, input int chg_inv, input int rst_row);
        int rc;
        rc = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                img[r][c] = pattern(pat, r, c);
        cfg_mode   = (mode != 0);
        cfg_offset = 9'(off);
        cfg_thresh = 8'(thr);
        cfg_invert = (inv != 0);
        pr_hit     = 1'b0;
        repeat (2) tick(1'b1, 1'b0, 1'b0, 8'h00, -1, -1);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 8'h00, -1, -1);
        for (int r = 0; r < h; r++) begin
            if (r == chg_row) cfg_invert = (chg_inv != 0);
            for (int c = 0; c < w; c++) begin
                if (r == rst_row && c == w / 2) begin
                    rst_pulse();
                    rc = 3;
                end
                tick(1'b0, 1'b1, 1'b1, img[r][c], r, c);
                if (rc > 0) begin
                    rc--;
                    if (rc == 0) rst_n = 1'b1;
                end
            end
            repeat (4) tick(1'b0, 1'b0, 1'b0, 8'h00, -1, -1);
        end
        repeat (6) tick(1'b0, 1'b0, 1'b0, 8'h00, -1, -1);
        if (pr_r >= 0) begin
            checks++;
            if (!pr_hit) begin
                errors++;
                $display("FAIL probe_seen (%0d,%0d) got 0 required 1", pr_r, pr_c);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{0,  16, 12, 0,   0, 128, 0,  5,   5, 8'h00};
        vecs[1]  = '{1,  16, 16, 0,   0, 128, 0, 11,  11, 8'hFF};
        vecs[2]  = '{1,  16, 16, 0,   0, 128, 0, 11,  12, 8'h00};
        vecs[3]  = '{2, 140,  4, 1,   0, 128, 0,  2, 129, 8'h00};
        vecs[4]  = '{2, 140,  4, 1,   0, 128, 0,  2, 130, 8'hFF};
        vecs[5]  = '{0,  16, 12, 0,   0, 128, 1,  5,   5, 8'hFF};
        vecs[6]  = '{0,  16, 12, 0,   0, 128, 1,  1,   5, 8'h00};
        vecs[7]  = '{0,  16, 12, 0,   0, 128, 1,  5,   1, 8'h00};
        vecs[8]  = '{0,  16, 12, 0,  -1, 128, 0,  5,   5, 8'hFF};
        vecs[9]  = '{3,  20, 12, 0, -10, 128, 0, -1,  -1, 8'h00};
        vecs[10] = '{3,  20, 12, 0, 255,  64, 1, -1,  -1, 8'h00};

        rst_n = 1'b0;
        pre_img_vsync = 1'b0; pre_img_hsync = 1'b0; pre_img_valid = 1'b0; pre_img_data = 8'h00;
        cfg_mode = 1'b0; cfg_offset = 9'd0; cfg_thresh = 8'h80; cfg_invert = 1'b0;
        run_m = 1'b0; vsp_m = 1'b0;
        mode_m = 0; off_m = 0; thr_m = 128; inv_m = 0;
        pr_r = -1; pr_c = -1; pr_v = 8'h00; pr_hit = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checks++; if (post_img_vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync got %b required 0", post_img_vsync); end
        checks++; if (post_img_hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync got %b required 0", post_img_hsync); end
        checks++; if (post_img_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", post_img_valid); end
        checks++; if (post_img_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h required 00", post_img_data); end
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            pr_r = vecs[i].pr; pr_c = vecs[i].pc; pr_v = vecs[i].pv;
            run_frame(vecs[i].pat, vecs[i].w, vecs[i].h, vecs[i].mode, vecs[i].off,
                      vecs[i].thr, vecs[i].inv, -1, 0, -1);
        end

        // invert toggled mid-frame is ignored; the following frame picks it up
        pr_r = 305; pr_c = 5; pr_v = 8'h00;
        run_frame(0, 8, 310, 0, 0, 128, 0, 300, 1, -1);
        pr_r = 5; pr_c = 5; pr_v = 8'hFF;
        run_frame(0, 8, 12, 0, 0, 128, 1, -1, 0, -1);

        // reset at row 200 drops the rest of the frame; the next one is normal
        pr_r = -1; pr_c = -1;
        run_frame(3, 8, 260, 0, -3, 128, 0, -1, 0, 200);
        run_frame(3, 16, 12, 0, -3, 128, 0, -1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
